// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the instrumented-adder measurement sequencer.
package adder_seq_pkg;

    localparam int unsigned WIDTH_DEF  = 32;
    localparam int unsigned WIN_W_DEF  = 16;
    localparam int unsigned SETTLE_DEF = 4;
    localparam int unsigned SYNC_DEF   = 3;

    localparam logic MODE_STATIC = 1'b0;
    localparam logic MODE_RING   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_RUN,
        ST_STOP,
        ST_CAPTURE,
        ST_DONE
    } seq_state_e;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down counter shared by the settle, ring-window and quiesce phases.
module seq_down_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero_c
);

    logic [W-1:0] r_cnt;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/adder_measure_sequencer.sv
// Sequences one instrumented-adder measurement: load, settle, optional ring window,
// quiesce, capture, done.
module adder_measure_sequencer
    import adder_seq_pkg::*;
#(
    parameter int unsigned WIDTH         = WIDTH_DEF,
    parameter int unsigned WIN_W         = WIN_W_DEF,
    parameter int unsigned SETTLE_CYCLES = SETTLE_DEF,
    parameter int unsigned SYNC_CYCLES   = SYNC_DEF
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic [WIDTH-1:0] a_operand,
    input  logic [WIDTH-1:0] b_operand,
    input  logic [WIN_W-1:0] window_cycles,
    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_b,
    output logic             ring_en,
    output logic             count_clr,
    input  logic [WIDTH-1:0] adder_sum,
    input  logic [WIDTH-1:0] ring_count,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_result,
    output logic [WIDTH-1:0] count_result,
    output logic             aborted
);

    localparam logic [WIN_W-1:0] SETTLE_LOAD = WIN_W'(SETTLE_CYCLES - 1);
    localparam logic [WIN_W-1:0] SYNC_LOAD   = WIN_W'(SYNC_CYCLES - 1);

    seq_state_e       r_state;
    logic             r_start_q;
    logic             r_mode;
    logic [WIN_W-1:0] r_window;

    logic             w_start_edge;
    logic             w_cnt_load;
    logic             w_cnt_en;
    logic             w_cnt_zero;
    logic [WIN_W-1:0] w_cnt_val;

    assign w_start_edge = start & ~r_start_q;

    // Phase timer control: reload on each phase entry, count while inside a timed phase.
    always_comb begin
        w_cnt_load = 1'b0;
        w_cnt_en   = 1'b0;
        w_cnt_val  = '0;
        case (r_state)
            ST_LOAD: begin
                w_cnt_load = 1'b1;
                w_cnt_val  = SETTLE_LOAD;
            end
            ST_SETTLE: begin
                if (w_cnt_zero) begin
                    w_cnt_load = 1'b1;
                    w_cnt_val  = (r_window == '0) ? SYNC_LOAD : (r_window - WIN_W'(1));
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_cnt_zero) begin
                    w_cnt_load = 1'b1;
                    w_cnt_val  = SYNC_LOAD;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            ST_STOP: begin
                w_cnt_en = 1'b1;
            end
            default: begin
                w_cnt_en = 1'b0;
            end
        endcase
    end

    seq_down_counter #(
        .W (WIN_W)
    ) u_phase_cnt (
        .clk        (wb_clk_i),
        .rst_n      (wb_rst_n),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_en       (w_cnt_en),
        .o_zero_c   (w_cnt_zero)
    );

    // Measurement FSM with registered outputs; abort overrides every non-idle state.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state      <= ST_IDLE;
            r_start_q    <= 1'b1;
            r_mode       <= MODE_STATIC;
            r_window     <= '0;
            adder_a      <= '0;
            adder_b      <= '0;
            ring_en      <= 1'b0;
            count_clr    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sum_result   <= '0;
            count_result <= '0;
            aborted      <= 1'b0;
        end else begin
            r_start_q <= start;
            count_clr <= 1'b0;
            done      <= 1'b0;
            if (abort && (r_state != ST_IDLE)) begin
                r_state <= ST_IDLE;
                ring_en <= 1'b0;
                busy    <= 1'b0;
                aborted <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_start_edge && !abort) begin
                            r_state   <= ST_LOAD;
                            busy      <= 1'b1;
                            count_clr <= 1'b1;
                            aborted   <= 1'b0;
                        end
                    end
                    ST_LOAD: begin
                        adder_a  <= a_operand;
                        adder_b  <= b_operand;
                        r_window <= window_cycles;
                        r_mode   <= mode;
                        r_state  <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (w_cnt_zero) begin
                            if (r_mode == MODE_STATIC) begin
                                r_state <= ST_CAPTURE;
                            end else if (r_window == '0) begin
                                r_state <= ST_STOP;
                            end else begin
                                r_state <= ST_RUN;
                                ring_en <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (w_cnt_zero) begin
                            r_state <= ST_STOP;
                            ring_en <= 1'b0;
                        end
                    end
                    ST_STOP: begin
                        if (w_cnt_zero) begin
                            r_state <= ST_CAPTURE;
                        end
                    end
                    ST_CAPTURE: begin
                        sum_result   <= adder_sum;
                        count_result <= (r_mode == MODE_RING) ? ring_count : '0;
                        done         <= 1'b1;
                        r_state      <= ST_DONE;
                    end
                    ST_DONE: begin
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adder_measure_sequencer.sv
// Self-checking bench for adder_measure_sequencer: cycle-level behavioural model plus
// directed scenarios with hand-computed results.
module tb_adder_measure_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        mode;
    logic [31:0] a_operand;
    logic [31:0] b_operand;
    logic [15:0] window_cycles;
    logic [31:0] adder_a;
    logic [31:0] adder_b;
    logic        ring_en;
    logic        count_clr;
    logic [31:0] adder_sum;
    logic [31:0] ring_count;
    logic        busy;
    logic        done;
    logic [31:0] sum_result;
    logic [31:0] count_result;
    logic        aborted;

    adder_measure_sequencer dut (
        .wb_clk_i      (clk),
        .wb_rst_n      (rst_n),
        .start         (start),
        .abort         (abort),
        .mode          (mode),
        .a_operand     (a_operand),
        .b_operand     (b_operand),
        .window_cycles (window_cycles),
        .adder_a       (adder_a),
        .adder_b       (adder_b),
        .ring_en       (ring_en),
        .count_clr     (count_clr),
        .adder_sum     (adder_sum),
        .ring_count    (ring_count),
        .busy          (busy),
        .done          (done),
        .sum_result    (sum_result),
        .count_result  (count_result),
        .aborted       (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_total = 0;
    int last_done_cyc = 0;
    int ring_hi = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Environment: combinational adder and a ring counter ticking once per ring_en clock.
    logic [31:0] rc;
    assign adder_sum  = adder_a + adder_b;
    assign ring_count = rc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)         rc <= 32'd0;
        else if (count_clr) rc <= 32'd0;
        else if (ring_en)   rc <= rc + 32'd1;
    end

    always @(posedge clk) cyc++;

    // Model: m_rel counts clocks since the accepted start edge (LOAD is 1, done at m_done_rel).
    logic        m_prev_start = 1'b1;
    logic        m_active = 1'b0;
    int          m_rel = 0;
    int          m_done_rel = 0;
    logic        m_mode = 1'b0;
    int          m_win = 0;
    logic [31:0] m_a = 0, m_b = 0;
    logic [31:0] e_a = 0, e_b = 0, e_sum = 0, e_cnt = 0;
    logic        e_aborted = 1'b0;
    logic        m_edge;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prev_start = 1'b1;
            m_active = 1'b0;
            m_rel = 0;
            e_a = 0; e_b = 0; e_sum = 0; e_cnt = 0;
            e_aborted = 1'b0;
        end else begin
            m_edge = start && !m_prev_start;
            m_prev_start = start;
            if (m_active) begin
                if (abort) begin
                    m_active = 1'b0;
                    e_aborted = 1'b1;
                end else if (m_rel == m_done_rel) begin
                    m_active = 1'b0;
                end else begin
                    m_rel++;
                    if (m_rel == 2) begin
                        e_a = m_a;
                        e_b = m_b;
                    end
                    if (m_rel == m_done_rel) begin
                        e_sum = m_a + m_b;
                        e_cnt = m_mode ? 32'(m_win) : 32'd0;
                    end
                end
            end else if (m_edge && !abort) begin
                m_active = 1'b1;
                m_rel = 1;
                e_aborted = 1'b0;
                m_a = a_operand;
                m_b = b_operand;
                m_mode = mode;
                m_win = int'(window_cycles);
                m_done_rel = 7 + (mode ? m_win + 3 : 0);
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_active));
        chk("count_clr", 32'(count_clr), 32'(m_active && m_rel == 1));
        chk("ring_en", 32'(ring_en), 32'(m_active && m_mode && m_rel >= 6 && m_rel < 6 + m_win));
        chk("done", 32'(done), 32'(m_active && m_rel == m_done_rel));
        chk("aborted", 32'(aborted), 32'(e_aborted));
        chk("adder_a", adder_a, e_a);
        chk("adder_b", adder_b, e_b);
        chk("sum_result", sum_result, e_sum);
        chk("count_result", count_result, e_cnt);
        if (done) begin
            done_total++;
            last_done_cyc = cyc;
        end
        if (ring_en) ring_hi++;
    end

    task automatic measure(input logic [31:0] a, input logic [31:0] b, input logic md,
                           input logic [15:0] win, input int lat, input logic [31:0] esum,
                           input logic [31:0] ecnt, input int ering, input bit glitch);
        int e0, d0, r0;
        bit got;
        a_operand = a;
        b_operand = b;
        mode = md;
        window_cycles = win;
        start = 1'b1;
        e0 = cyc;
        d0 = done_total;
        r0 = ring_hi;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (glitch && cyc == e0 + 3) start = 1'b0;
            if (glitch && cyc == e0 + 5) start = 1'b1;
            if (done_total != d0) got = 1'b1;
        end
        if (!got) chk("done_timeout", 32'd0, 32'd1);
        else      chk("latency", 32'(last_done_cyc - e0), 32'(lat));
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("lit_sum", sum_result, esum);
        chk("lit_count", count_result, ecnt);
        chk("lit_ring_cycles", 32'(ring_hi - r0), 32'(ering));
        chk("lit_done_count", 32'(done_total - d0), 32'd1);
    endtask

    initial begin
        int d0;
        rst_n = 1'b1;
        start = 1'b1;
        abort = 1'b0;
        mode = 1'b0;
        a_operand = 0;
        b_operand = 0;
        window_cycles = 0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // start held high through reset release must not launch
        repeat (4) @(negedge clk);
        chk("lit_no_launch_busy", 32'(busy), 32'd0);
        chk("lit_no_launch_done", 32'(done_total), 32'd0);
        start = 1'b0;
        repeat (2) @(negedge clk);

        measure(32'h3, 32'h5, 1'b0, 16'd0, 7, 32'h8, 32'h0, 0, 1'b0);
        measure(32'h7, 32'h9, 1'b1, 16'd0, 10, 32'h10, 32'h0, 0, 1'b0);
        measure(32'h100, 32'h23, 1'b1, 16'd10, 20, 32'h123, 32'd10, 10, 1'b1);

        // abort in the third ring cycle of a 100-cycle window
        a_operand = 32'h10;
        b_operand = 32'h20;
        mode = 1'b1;
        window_cycles = 16'd100;
        start = 1'b1;
        d0 = done_total;
        repeat (8) @(negedge clk);
        chk("lit_ring_before_abort", 32'(ring_en), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("lit_abort_ring", 32'(ring_en), 32'd0);
        chk("lit_abort_busy", 32'(busy), 32'd0);
        chk("lit_abort_flag", 32'(aborted), 32'd1);
        repeat (5) @(negedge clk);
        chk("lit_abort_no_done", 32'(done_total - d0), 32'd0);
        chk("lit_abort_sum_kept", sum_result, 32'h123);
        chk("lit_abort_cnt_kept", count_result, 32'd10);

        measure(32'hFFFF_FFFF, 32'h1, 1'b0, 16'd0, 7, 32'h0, 32'h0, 0, 1'b0);
        chk("lit_aborted_cleared", 32'(aborted), 32'd0);

        // abort together with a start edge in idle: abort wins
        d0 = done_total;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (4) @(negedge clk);
        chk("lit_abort_idle_busy", 32'(busy), 32'd0);
        chk("lit_abort_idle_done", 32'(done_total - d0), 32'd0);
        start = 1'b0;
        repeat (2) @(negedge clk);

        // async reset in the middle of a ring window
        a_operand = 32'h55;
        b_operand = 32'h66;
        mode = 1'b1;
        window_cycles = 16'd50;
        start = 1'b1;
        repeat (10) @(negedge clk);
        chk("lit_ring_before_reset", 32'(ring_en), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("lit_rst_ring", 32'(ring_en), 32'd0);
        chk("lit_rst_busy", 32'(busy), 32'd0);
        chk("lit_rst_done", 32'(done), 32'd0);
        chk("lit_rst_sum", sum_result, 32'd0);
        chk("lit_rst_count", count_result, 32'd0);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        measure(32'h3, 32'h5, 1'b0, 16'd0, 7, 32'h8, 32'h0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
